// File: rtl/chip_ram_dp_if.sv
// Port bundle for chip_ram_dp: clear handshake plus the two RAM access ports.
interface chip_ram_dp_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12
);
    logic              clear;
    logic              busy;
    logic              ena;
    logic              enb;
    logic              wa;
    logic              wb;
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ab;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic              qa_valid;
    logic              qb_valid;
    logic              collision;

    // Requester side (CPU / DMA / bench)
    modport master (
        output clear, ena, enb, wa, wb, aa, ab, da, db,
        input  busy, qa, qb, qa_valid, qb_valid, collision
    );

    // Memory side
    modport slave (
        input  clear, ena, enb, wa, wb, aa, ab, da, db,
        output busy, qa, qb, qa_valid, qb_valid, collision
    );
endinterface

// File: rtl/chip_ram_dp.sv
// True dual-port synchronous RAM with selectable read-during-write behaviour,
// port-A-wins write collisions and a sequential clear engine run after reset.
module chip_ram_dp #(
    parameter int unsigned            DATA_W    = 8,
    parameter int unsigned            ADDR_W    = 12,
    parameter int unsigned            RDW_MODE  = 0,
    parameter logic [DATA_W-1:0]      CLEAR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    chip_ram_dp_if.slave  bus
);
    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              clr_we;
    logic              acc_ok;
    logic              a_wr;
    logic              b_wr;
    logic              col_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] qa_q;
    logic [DATA_W-1:0] qb_q;
    logic              qa_valid_q;
    logic              qb_valid_q;
    logic              collision_q;

    // Clear engine state and sweep counter; reset starts a fresh sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear engine next state; explicit terminal compare ends the sweep at DEPTH-1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        acc_ok  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    acc_ok = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Write qualification; on a same-address double write port B is dropped
    always_comb begin
        a_wr  = acc_ok & bus.ena & bus.wa;
        col_d = a_wr & bus.enb & bus.wb & (bus.aa == bus.ab);
        b_wr  = acc_ok & bus.enb & bus.wb & ~col_d;
    end

    // Memory array (not reset); the clear sweep owns the array while busy
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= CLEAR_VAL;
        end else begin
            if (b_wr) begin
                mem[bus.ab] <= bus.db;
            end
            if (a_wr) begin
                mem[bus.aa] <= bus.da;
            end
        end
    end

    // Registered read ports; non-blocking reads give cross-port readers the old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa_q        <= '0;
            qb_q        <= '0;
            qa_valid_q  <= 1'b0;
            qb_valid_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            qa_valid_q  <= 1'b0;
            qb_valid_q  <= 1'b0;
            collision_q <= col_d;
            if (acc_ok && bus.ena) begin
                qa_q       <= (bus.wa && RDW_MODE == 0) ? bus.da : mem[bus.aa];
                qa_valid_q <= 1'b1;
            end
            if (acc_ok && bus.enb) begin
                qb_q       <= (bus.wb && RDW_MODE == 0) ? bus.db : mem[bus.ab];
                qb_valid_q <= 1'b1;
            end
        end
    end

    assign bus.busy      = (state_q == ST_CLEAR);
    assign bus.qa        = qa_q;
    assign bus.qb        = qb_q;
    assign bus.qa_valid  = qa_valid_q;
    assign bus.qb_valid  = qb_valid_q;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_chip_ram_dp.sv
// Bench for chip_ram_dp: write-first and read-first instances share one stimulus
// stream; a reference model pushes expectations that are popped after each edge.
module tb_chip_ram_dp;
    localparam logic [7:0] CV = 8'hA5;

    logic clk;
    logic rst_n;

    chip_ram_dp_if #(.DATA_W(8), .ADDR_W(4)) bus0 ();
    chip_ram_dp_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();

    assign bus1.clear = bus0.clear;
    assign bus1.ena   = bus0.ena;
    assign bus1.enb   = bus0.enb;
    assign bus1.wa    = bus0.wa;
    assign bus1.wb    = bus0.wb;
    assign bus1.aa    = bus0.aa;
    assign bus1.ab    = bus0.ab;
    assign bus1.da    = bus0.da;
    assign bus1.db    = bus0.db;

    chip_ram_dp #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0), .CLEAR_VAL(CV)) u_dut_wf (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    chip_ram_dp #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1), .CLEAR_VAL(CV)) u_dut_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct packed {
        logic [7:0] qa_wf;
        logic [7:0] qa_rf;
        logic [7:0] qb_wf;
        logic [7:0] qb_rf;
        logic       va;
        logic       vb;
        logic       col;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_mem [16];
    logic       m_busy;
    int         m_cnt;
    logic [7:0] m_qa_wf, m_qa_rf, m_qb_wf, m_qb_rf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, model the edge, compare after it
    task automatic step(input logic clr, input logic ena, input logic wa, input logic [3:0] aa,
                        input logic [7:0] da, input logic enb, input logic wb,
                        input logic [3:0] ab, input logic [7:0] db);
        exp_t       e;
        logic [7:0] old_a;
        logic [7:0] old_b;
        logic       col;
        bus0.clear = clr;
        bus0.ena = ena; bus0.wa = wa; bus0.aa = aa; bus0.da = da;
        bus0.enb = enb; bus0.wb = wb; bus0.ab = ab; bus0.db = db;
        e.va = 1'b0; e.vb = 1'b0; e.col = 1'b0;
        if (m_busy) begin
            m_mem[m_cnt] = CV;
            if (m_cnt == 15) m_busy = 1'b0;
            m_cnt++;
        end else if (clr) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else begin
            old_a = m_mem[aa];
            old_b = m_mem[ab];
            col = ena & wa & enb & wb & (aa == ab);
            if (ena) begin
                e.va = 1'b1;
                m_qa_wf = wa ? da : old_a;
                m_qa_rf = old_a;
            end
            if (enb) begin
                e.vb = 1'b1;
                m_qb_wf = wb ? db : old_b;
                m_qb_rf = old_b;
            end
            e.col = col;
            if (enb && wb && !col) m_mem[ab] = db;
            if (ena && wa) m_mem[aa] = da;
        end
        e.qa_wf = m_qa_wf; e.qa_rf = m_qa_rf;
        e.qb_wf = m_qb_wf; e.qb_rf = m_qb_rf;
        e.busy  = m_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("qa_wf", bus0.qa, e.qa_wf);
        check("qa_rf", bus1.qa, e.qa_rf);
        check("qb_wf", bus0.qb, e.qb_wf);
        check("qb_rf", bus1.qb, e.qb_rf);
        check("qa_valid", bus0.qa_valid, e.va);
        check("qb_valid", bus0.qb_valid, e.vb);
        check("qa_valid_rf", bus1.qa_valid, e.va);
        check("collision", bus0.collision, e.col);
        check("collision_rf", bus1.collision, e.col);
        check("busy", bus0.busy, e.busy);
        check("busy_rf", bus1.busy, e.busy);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    // Idle until the sweep ends (bounded); returns the number of edges spent
    task automatic wait_sweep(output int n);
        n = 0;
        while (bus0.busy === 1'b1 && n < 100) begin
            idle();
            n++;
        end
    endtask

    // Asynchronous reset applied away from any edge, released on a negedge
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_busy = 1'b1; m_cnt = 0;
        m_qa_wf = 8'd0; m_qa_rf = 8'd0; m_qb_wf = 8'd0; m_qb_rf = 8'd0;
        check("rst_qa", bus0.qa, 8'h00);
        check("rst_qb_rf", bus1.qb, 8'h00);
        check("rst_qa_valid", bus0.qa_valid, 1'b0);
        check("rst_qb_valid", bus0.qb_valid, 1'b0);
        check("rst_collision", bus0.collision, 1'b0);
        check("rst_busy", bus0.busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 8'd0, 1'b1, 1'b0, 4'(15 - i), 8'd0);
            check(tag, bus0.qa, CV);
            check(tag, bus1.qb, CV);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus0.clear = 1'b0;
        bus0.ena = 1'b0; bus0.wa = 1'b0; bus0.aa = '0; bus0.da = '0;
        bus0.enb = 1'b0; bus0.wb = 1'b0; bus0.ab = '0; bus0.db = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        @(negedge clk);

        // Reset then power-on sweep: exactly 16 busy edges
        do_reset();
        wait_sweep(n);
        check("por_sweep_edges", n, 16);
        read_all("por_read");

        // Basic write on A, read on B next edge
        step(1'b0, 1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b0, 4'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd5, 8'd0);
        check("basic_qb", bus0.qb, 8'h3C);
        check("basic_qb_valid", bus0.qb_valid, 1'b1);

        // Same-port read-during-write
        step(1'b0, 1'b1, 1'b1, 4'd2, 8'h11, 1'b0, 1'b0, 4'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b0, 4'd0, 8'd0);
        check("rdw_wf", bus0.qa, 8'h22);
        check("rdw_rf", bus1.qa, 8'h11);
        step(1'b0, 1'b1, 1'b0, 4'd2, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        check("rdw_after_wf", bus0.qa, 8'h22);
        check("rdw_after_rf", bus1.qa, 8'h22);

        // Write collision: A wins, B's write dropped
        step(1'b0, 1'b1, 1'b1, 4'd9, 8'h77, 1'b1, 1'b1, 4'd9, 8'h88);
        check("col_pulse", bus0.collision, 1'b1);
        check("col_qb_wf", bus0.qb, 8'h88);
        check("col_qb_rf", bus1.qb, CV);
        step(1'b0, 1'b1, 1'b0, 4'd9, 8'd0, 1'b1, 1'b0, 4'd9, 8'd0);
        check("col_clear", bus0.collision, 1'b0);
        check("col_read_a", bus0.qa, 8'h77);
        check("col_read_b", bus1.qb, 8'h77);

        // Cross-port read during write returns old data
        step(1'b0, 1'b1, 1'b1, 4'd4, 8'h01, 1'b0, 1'b0, 4'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 4'd4, 8'h02, 1'b1, 1'b0, 4'd4, 8'd0);
        check("cross_old", bus0.qb, 8'h01);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd4, 8'd0);
        check("cross_new", bus0.qb, 8'h02);

        // Both ports reading the same address, then disabled ports hold
        step(1'b0, 1'b1, 1'b0, 4'd5, 8'd0, 1'b1, 1'b0, 4'd5, 8'd0);
        check("dual_read", bus0.qa, 8'h3C);
        idle();
        check("hold_qa", bus0.qa, 8'h3C);
        check("hold_valid", bus0.qa_valid, 1'b0);

        // Randomised traffic with frequent address overlap
        for (int i = 0; i < 60; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            step(1'b0, 1'($urandom), 1'($urandom), a, 8'($urandom),
                 1'($urandom), 1'($urandom), b, 8'($urandom));
        end

        // Requested clear with a write attempted during the sweep
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 4'd5, 8'h3C, 1'b1, 1'b1, 4'd6, 8'h44);
        wait_sweep(n);
        check("req_sweep_edges", n + 2, 17);
        read_all("req_read");

        // Clear pulsed mid-sweep does not restart it
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(); idle(); idle();
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        wait_sweep(n);
        check("reclear_edges", n + 5, 17);

        // Reset mid-sweep restarts from address 0
        step(1'b0, 1'b1, 1'b1, 4'd0, 8'h5A, 1'b1, 1'b1, 4'd5, 8'h3C);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(); idle(); idle(); idle(); idle();
        do_reset();
        wait_sweep(n);
        check("abort_sweep_edges", n, 16);
        read_all("abort_read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/chip_ram_dp.md
# chip_ram_dp

Parametrised true dual-port synchronous RAM with per-port enables, selectable read-during-write behaviour, deterministic write-collision arbitration and a built-in sequential clear engine. It serves as the CHIP-8 main memory, and can also be instantiated for smaller stores such as the display buffer or stack. The CPU uses port A and the display/DMA side uses port B. After every reset, and on request, the clear engine fills the whole array with a fixed value.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words
- RDW_MODE, 0, same-port read-during-write behaviour: 0 = write-first (q shows new data), 1 = read-first (q shows old data)
- CLEAR_VAL, 0, DATA_W-bit value written by the clear engine

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  clear request; sampled only when idle
- busy  out  1  clear engine active; external accesses are ignored while high
- ena, enb  in  1 each  port enable
- wa, wb  in  1 each  write enable; qualified by the port enable
- aa, ab  in  ADDR_W each  address
- da, db  in  DATA_W each  write data
- qa, qb  out  DATA_W each  registered read data
- qa_valid, qb_valid  out  1 each  q was updated by an access on the previous edge
- collision  out  1  one-cycle pulse: both ports wrote the same address on the previous edge

## Operation
- Reset (rst_n low, asynchronous): busy=1, clear counter=0, qa=qb=0, qa_valid=qb_valid=0, collision=0. The memory array itself is not reset.
- Clear engine, with states IDLE and CLEAR:
  - Reset places the engine in CLEAR.
  - In CLEAR, each edge writes CLEAR_VAL to mem[counter] and increments the counter.
  - On the edge that writes address DEPTH-1, the engine returns to IDLE and busy falls.
  - In IDLE, an edge with clear=1 sets busy=1, resets the counter to 0 and enters CLEAR. No array write occurs on that edge.
  - clear asserted during CLEAR is ignored; the sweep does not restart.
  - Reset asserted mid-sweep restarts the sweep from address 0 after release.
- While busy=1: all port accesses are ignored, qa/qb hold their values, and valid and collision are 0.
- Port access, when idle and enX=1:
  - If wX=1: mem[aX] <= dX. qX becomes dX when RDW_MODE=0, or the old mem[aX] when RDW_MODE=1.
  - If wX=0: qX <= mem[aX].
  - In both cases qX_valid <= 1.
- When idle and enX=0: qX holds and qX_valid <= 0.
- Write collision (wa & ena & wb & enb with aa==ab): port A's data is stored and port B's write is dropped. collision <= 1. qb follows RDW_MODE with port B's own data (qb=db in write-first mode), so qb does not reflect the stored value.
- Cross-port read during write (one port writes, the other reads the same address): the reading port always receives the old contents.
- Both ports reading the same address: both receive the same data with no interaction.

## Timing
- Read latency is one cycle: address presented before edge N, data and valid on q after edge N.
- Write latency is one cycle: a read issued on edge N+1 returns data written on edge N.
- A clear after reset release takes exactly DEPTH edges. busy is low after the DEPTH-th rising edge following rst_n release.
- A requested clear takes DEPTH+1 edges: 1 acceptance edge plus DEPTH write edges.
- collision, qa_valid and qb_valid are registered and aligned with the q data of the access they describe.
- Addresses are unsigned ADDR_W bits with no wrap logic needed. The clear counter has ADDR_W+1 bits or an explicit terminal compare, so DEPTH-1 terminates correctly.

## Test plan
Benches run with ADDR_W=4, DATA_W=8 and CLEAR_VAL=8'hA5 unless noted.
- Reset-then-clear: release rst_n, then read all 16 addresses on port A -> busy high for exactly 16 edges; every read returns A5 with qa_valid=1 one cycle later.
- Basic R/W: A writes 8'h3C to address 5, then B reads address 5 on the next edge -> qb=3C, qb_valid=1 one cycle after the read.
- RDW mode: mem[2]=11, then A writes 22 to address 2 -> qa=22 with RDW_MODE=0 and qa=11 with RDW_MODE=1; a later read returns 22 in both modes.
- Collision: A writes 77 and B writes 88 to address 9 on the same edge -> collision=1 for one cycle; a subsequent read of address 9 returns 77.
- Cross-port: mem[4]=01, A writes 02 to address 4 while B reads address 4 -> qb=01; the next B read returns 02.
- Clear request and abort:
  - Pulse clear while idle and drive a write during the sweep -> busy lasts 17 edges, the write is ignored and all locations read A5.
  - Assert rst_n low mid-sweep -> qa=0, valid=0, and the sweep restarts from address 0.
